// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: FSM state encodings, bus width constants and byte-lane
// constants for the data-memory bridge.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_SEL_W  = BUS_DATA_W / 8;

    // Big-endian lanes: bit 3 selects bits [31:24], which is byte offset 00
    localparam logic [BUS_SEL_W-1:0] SEL_B0    = 4'b1000;
    localparam logic [BUS_SEL_W-1:0] SEL_B1    = 4'b0100;
    localparam logic [BUS_SEL_W-1:0] SEL_B2    = 4'b0010;
    localparam logic [BUS_SEL_W-1:0] SEL_B3    = 4'b0001;
    localparam logic [BUS_SEL_W-1:0] SEL_HALF0 = 4'b1100;
    localparam logic [BUS_SEL_W-1:0] SEL_HALF1 = 4'b0011;
    localparam logic [BUS_SEL_W-1:0] SEL_WORD  = 4'b1111;

endpackage

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: one-entry posted-store holder (valid, addr, sel, wdata)
// with push/pop; push wins if both are asserted together.
module dmem_store_buffer
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [SEL_W-1:0]  push_sel,
    input  logic [DATA_W-1:0] push_wdata,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] wdata
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            sel   <= '0;
            wdata <= '0;
        end else if (push) begin
            valid <= 1'b1;
            addr  <= push_addr;
            sel   <= push_sel;
            wdata <= push_wdata;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the memory stage's single-cycle access into a valid/ready
// bus transaction and stalls until it completes. DMEM_STORE_BUFFER_EN adds a one-entry posted store buffer.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_ce,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                stall_o,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_we,
    output logic [DATA_W/8-1:0] bus_req_sel,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [DATA_W-1:0]   bus_req_wdata,
    input  logic                bus_resp_valid,
    input  logic [DATA_W-1:0]   bus_resp_rdata
);

    localparam int SEL_W = DATA_W / 8;

    state_t            state, state_nx;
    logic              drop, drop_nx, dropped, launch, drain;
    logic              src_we;
    logic [SEL_W-1:0]  src_sel;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;

`ifdef DMEM_STORE_BUFFER_EN
    logic              sb_valid, sb_push, sb_pop;
    logic [ADDR_W-1:0] sb_addr;
    logic [SEL_W-1:0]  sb_sel;
    logic [DATA_W-1:0] sb_wdata;

    assign sb_push = state == IDLE && req_ce && req_we && !sb_valid && !flush;
    assign sb_pop  = state == WAIT && bus_resp_valid && sb_valid;

    dmem_store_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .SEL_W (SEL_W)
    ) u_store_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (sb_push),
        .pop       (sb_pop),
        .push_addr (req_addr),
        .push_sel  (req_sel),
        .push_wdata(req_wdata),
        .valid     (sb_valid),
        .addr      (sb_addr),
        .sel       (sb_sel),
        .wdata     (sb_wdata)
    );

    // An occupied buffer is drained before anything else is launched
    assign drain     = sb_valid;
    assign launch    = state == IDLE && (sb_valid || (req_ce && !flush && !sb_push));
    assign src_we    = sb_valid || req_we;
    assign src_sel   = sb_valid ? sb_sel : req_sel;
    assign src_addr  = sb_valid ? sb_addr : req_addr;
    assign src_wdata = sb_valid ? sb_wdata : req_wdata;
    assign stall_o   = req_ce && state != DONE && !sb_push;
`else
    assign drain     = 1'b0;
    assign launch    = state == IDLE && req_ce && !flush;
    assign src_we    = req_we;
    assign src_sel   = req_sel;
    assign src_addr  = req_addr;
    assign src_wdata = req_wdata;
    assign stall_o   = req_ce && state != DONE;
`endif

    // A flush in the response cycle itself must also suppress the load result
    assign dropped = drop || flush;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = launch ? REQ : IDLE;
            REQ:     state_nx = bus_req_ready ? WAIT : REQ;
            WAIT:    state_nx = !bus_resp_valid ? WAIT : (dropped || drain) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        drop_nx = state_nx == IDLE ? 1'b0 : drop || (flush && (state == REQ || state == WAIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            drop          <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_sel   <= '0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            rdata_o       <= '0;
        end else begin
            state         <= state_nx;
            drop          <= drop_nx;
            bus_req_valid <= state_nx == REQ;
            if (launch) begin
                bus_req_we    <= src_we;
                bus_req_sel   <= src_sel;
                bus_req_addr  <= src_addr;
                bus_req_wdata <= src_wdata;
            end
            if (state == WAIT && bus_resp_valid && !bus_req_we && !dropped)
                rdata_o <= bus_resp_rdata;
        end
    end

endmodule
